// File: rtl/fc_layer_sched_if.sv
// ============================================================================
// Module : fc_layer_sched_if
// Brief  : Control, weight-fetch and result handshake bundle for fc_layer_sched
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface fc_layer_sched_if #(
    parameter int OUT_WIDTH  = 64,
    parameter int ADDR_WIDTH = 4
);
    logic                         start;
    logic                         busy;
    logic                         done;
    logic                         w_rd_en;
    logic        [ADDR_WIDTH-1:0] w_addr;
    logic signed [OUT_WIDTH-1:0]  dp_sum;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic        [ADDR_WIDTH-1:0] out_idx;

    // master: the system driving the scheduler (controller, datapath, sink)
    modport master (
        output start, dp_sum, out_ready,
        input  busy, done, w_rd_en, w_addr, out_valid, out_data, out_idx
    );

    // slave: the scheduler itself
    modport slave (
        input  start, dp_sum, out_ready,
        output busy, done, w_rd_en, w_addr, out_valid, out_data, out_idx
    );
endinterface

`default_nettype wire

// File: rtl/fc_layer_sched.sv
// ============================================================================
// Module : fc_layer_sched
// Brief  : Sequences one fully-connected layer pass, one neuron at a time,
//          over a shared dot-product datapath. Optional ReLU on the captured
//          result when FC_LAYER_SCHED_RELU_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fc_layer_sched #(
    parameter int N_OUT      = 10,
    parameter int OUT_WIDTH  = 64,
    parameter int ADDR_WIDTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fc_layer_sched_if.slave   bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_OUTPUT = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] c_last_idx = ADDR_WIDTH'(N_OUT - 1);

    logic [2:0]                  r_state;
    logic [2:0]                  w_next;
    logic [ADDR_WIDTH-1:0]       r_idx;
    logic signed [OUT_WIDTH-1:0] r_out_data;
    logic [ADDR_WIDTH-1:0]       r_out_idx;
    logic signed [OUT_WIDTH-1:0] w_capture;
    logic                        w_accept;

    assign w_accept = (r_state == S_OUTPUT) && bus.out_ready;

`ifdef FC_LAYER_SCHED_RELU_EN
    assign w_capture = bus.dp_sum[OUT_WIDTH-1] ? '0 : bus.dp_sum;
`else
    assign w_capture = bus.dp_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_FETCH;
            S_FETCH:  w_next = S_WAIT;
            S_WAIT:   w_next = S_OUTPUT;
            S_OUTPUT: if (w_accept) w_next = (r_idx == c_last_idx) ? S_DONE : S_FETCH;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (r_state != S_IDLE);
        bus.done      = (r_state == S_DONE);
        bus.w_rd_en   = (r_state == S_FETCH);
        bus.w_addr    = r_idx;
        bus.out_valid = (r_state == S_OUTPUT);
        bus.out_data  = r_out_data;
        bus.out_idx   = r_out_idx;
    end

    // Index advances only on acceptance of a non-final result, so it saturates at the last neuron
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_out_data <= '0;
            r_out_idx  <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_idx <= '0;
            end else if (w_accept && r_idx != c_last_idx) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == S_WAIT) begin
                r_out_data <= w_capture;
                r_out_idx  <= r_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fc_layer_sched.sv
// ============================================================================
// Module : tb_fc_layer_sched
// Brief  : Self-checking bench for fc_layer_sched (table-driven pass checks
//          plus directed stall, held-start, mid-pass reset and ReLU cases)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fc_layer_sched;

    localparam int N_OUT      = 10;
    localparam int OUT_WIDTH  = 64;
    localparam int ADDR_WIDTH = 4;

    typedef struct {
        logic [ADDR_WIDTH-1:0]       idx;
        logic signed [OUT_WIDTH-1:0] data;
        int                          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   rd_cnt = 0;
    int   neg_idx = -1;
    int   t0 = 0;
    vec_t vecs [N_OUT];

    logic [ADDR_WIDTH-1:0]       row = '0;
    logic signed [OUT_WIDTH-1:0] dp_model;

    fc_layer_sched_if #(.OUT_WIDTH(OUT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    fc_layer_sched #(
        .N_OUT(N_OUT), .OUT_WIDTH(OUT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Weight memory plus datapath model: 1-cycle read latency, sum = 100 + row
    always_ff @(posedge clk) begin
        if (bus.w_rd_en) row <= bus.w_addr;
    end

    always_comb begin
        if (int'(row) == neg_idx) dp_model = -64'sd5;
        else                      dp_model = 64'sd100 + OUT_WIDTH'(row);
    end
    assign bus.dp_sum = dp_model;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        done_cnt += int'(bus.done);
        rd_cnt   += int'(bus.w_rd_en);
        if (bus.w_rd_en) check("w_addr_range", 64'(bus.w_addr < N_OUT), 64'sd1);
    endtask

    task automatic do_start(output int ts);
        bus.start = 1'b1;
        ts = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_pass(input int ts);
        int n;
        for (int k = 0; k < N_OUT; k++) begin
            n = 0;
            while (!bus.out_valid && n < 12) begin
                tick();
                n++;
            end
            check("out_valid_timeout", 64'(bus.out_valid), 64'sd1);
            check("out_latency", 64'(cyc - ts), 64'(vecs[k].lat));
            check("out_data", bus.out_data, vecs[k].data);
            check("out_idx", 64'(bus.out_idx), 64'(vecs[k].idx));
            tick();
        end
        check("done_pulse", 64'(bus.done), 64'sd1);
        check("done_cycle", 64'(cyc - ts), 64'(3 * N_OUT + 1));
        tick();
        check("done_cleared", 64'(bus.done), 64'sd0);
        check("idle_busy", 64'(bus.busy), 64'sd0);
    endtask

    initial begin
        int n;
        for (int k = 0; k < N_OUT; k++) begin
            vecs[k].idx  = ADDR_WIDTH'(k);
            vecs[k].data = 64'(100 + k);
            vecs[k].lat  = 3 + 3 * k;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        check("rst_busy", 64'(bus.busy), 64'sd0);
        check("rst_done", 64'(bus.done), 64'sd0);
        check("rst_w_rd_en", 64'(bus.w_rd_en), 64'sd0);
        check("rst_w_addr", 64'(bus.w_addr), 64'sd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'sd0);
        check("rst_out_data", bus.out_data, 64'sd0);
        check("rst_out_idx", 64'(bus.out_idx), 64'sd0);
        rst_n = 1'b1;
        tick();

        // Full pass, sink always ready
        done_cnt = 0;
        rd_cnt   = 0;
        do_start(t0);
        check("first_rd_en", 64'(bus.w_rd_en), 64'sd1);
        check("first_w_addr", 64'(bus.w_addr), 64'sd0);
        check("busy_after_start", 64'(bus.busy), 64'sd1);
        run_pass(t0);
        check("pass_rd_count", 64'(rd_cnt), 64'(N_OUT));
        check("pass_done_count", 64'(done_cnt), 64'sd1);

        // Back-pressure on neuron 3
        done_cnt = 0;
        do_start(t0);
        n = 0;
        while (!(bus.out_valid && bus.out_idx == 3) && n < 40) begin
            tick();
            n++;
        end
        check("stall_reach_idx3", 64'(bus.out_idx), 64'sd3);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            check("stall_valid", 64'(bus.out_valid), 64'sd1);
            check("stall_data", bus.out_data, 64'sd103);
            check("stall_idx", 64'(bus.out_idx), 64'sd3);
            check("stall_no_rd", 64'(bus.w_rd_en), 64'sd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("resume_rd_en", 64'(bus.w_rd_en), 64'sd1);
        check("resume_w_addr", 64'(bus.w_addr), 64'sd4);
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check("stall_done", 64'(bus.done), 64'sd1);
        check("stall_done_count", 64'(done_cnt), 64'sd1);
        tick();

        // Start held high for the whole pass
        done_cnt = 0;
        rd_cnt   = 0;
        bus.start = 1'b1;
        t0 = cyc;
        n = 0;
        while (!bus.done && n < 60) begin
            tick();
            n++;
        end
        check("held_done", 64'(bus.done), 64'sd1);
        check("held_done_cycle", 64'(cyc - t0), 64'(3 * N_OUT + 1));
        check("held_rd_count", 64'(rd_cnt), 64'(N_OUT));
        check("held_done_count", 64'(done_cnt), 64'sd1);
        tick();
        check("held_idle_busy", 64'(bus.busy), 64'sd0);
        check("held_idle_rd", 64'(bus.w_rd_en), 64'sd0);
        tick();
        check("held_restart_rd", 64'(bus.w_rd_en), 64'sd1);
        check("held_restart_addr", 64'(bus.w_addr), 64'sd0);
        bus.start = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset during WAIT of neuron 6
        done_cnt = 0;
        do_start(t0);
        n = 0;
        while (!(bus.w_rd_en && bus.w_addr == 6) && n < 40) begin
            tick();
            n++;
        end
        check("rst_reach_fetch6", 64'(bus.w_addr), 64'sd6);
        tick();
        check("pre_rst_data", bus.out_data, 64'sd105);
        rst_n = 1'b0;
        #1;
        check("async_busy", 64'(bus.busy), 64'sd0);
        check("async_done", 64'(bus.done), 64'sd0);
        check("async_w_rd_en", 64'(bus.w_rd_en), 64'sd0);
        check("async_w_addr", 64'(bus.w_addr), 64'sd0);
        check("async_out_valid", 64'(bus.out_valid), 64'sd0);
        check("async_out_data", bus.out_data, 64'sd0);
        check("async_out_idx", 64'(bus.out_idx), 64'sd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("rst_no_done", 64'(done_cnt), 64'sd0);
        do_start(t0);
        check("post_rst_rd_en", 64'(bus.w_rd_en), 64'sd1);
        check("post_rst_w_addr", 64'(bus.w_addr), 64'sd0);
        run_pass(t0);

        // Negative sum on neuron 2
        neg_idx = 2;
`ifdef FC_LAYER_SCHED_RELU_EN
        vecs[2].data = 64'sd0;
`else
        vecs[2].data = -64'sd5;
`endif
        do_start(t0);
        run_pass(t0);
        neg_idx = -1;
        vecs[2].data = 64'sd102;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/fc_layer_sched.md
FC_LAYER_SCHED -- requirements
Module: fc_layer_sched

Interface
REQ-001 The block SHALL have parameter N_OUT, default 10, giving the number of output neurons sequenced per layer pass.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 64, giving the dot-product result width.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 4, giving the weight/bias row address width (2^ADDR_WIDTH >= N_OUT).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one full layer pass; sampled in IDLE only.
REQ-007 busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-008 done  output  1  one-cycle pulse after the last neuron result is accepted.
REQ-009 w_rd_en  output  1  read strobe to the weight/bias row memory (1-cycle read latency).
REQ-010 w_addr  output  ADDR_WIDTH  row index = current neuron index.
REQ-011 dp_sum  input  signed OUT_WIDTH  combinational dot-product-plus-bias from the shared FC datapath, valid the cycle after w_rd_en.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream accepts result when high with out_valid.
REQ-014 out_data  output  signed OUT_WIDTH  registered neuron result.
REQ-015 out_idx  output  ADDR_WIDTH  neuron index of out_data.

Function
REQ-016 FSM states: IDLE, FETCH, WAIT, OUTPUT, DONE.
REQ-017 IDLE: start=1 -> FETCH with neuron index cleared to 0; start=0 -> stay.
REQ-018 FETCH (1 cycle): w_rd_en=1, w_addr=index; -> WAIT.
REQ-019 WAIT (1 cycle): out_data <= dp_sum (after optional ReLU), out_idx <= index; -> OUTPUT.
REQ-020 OUTPUT: out_valid=1; out_data/out_idx stable while out_ready=0; on out_valid&out_ready, if index==N_OUT-1 -> DONE, else index+1 and -> FETCH.
REQ-021 DONE (1 cycle): done=1; -> IDLE; start in DONE ignored.
REQ-022 start while busy SHALL be ignored, not queued.
REQ-023 Latency: start high in cycle T (IDLE) -> w_rd_en in T+1 -> out_valid in T+3; with out_ready held high, one result per 3 cycles, done in cycle T+3*N_OUT+1.
REQ-024 Index SHALL NOT wrap past N_OUT-1; w_addr never exceeds N_OUT-1.
REQ-025 w_rd_en high only in FETCH; out_valid high only in OUTPUT; done high only in DONE.
REQ-026 dp_sum passed at full OUT_WIDTH, no truncation or saturation.

Reset
REQ-027 rst_n low at any time SHALL force IDLE immediately: busy=0, done=0, w_rd_en=0, w_addr=0, out_valid=0, out_data=0, out_idx=0, index=0.
REQ-028 Reset mid-pass SHALL discard the pass; no done pulse; next pass restarts at index 0.

Configuration
REQ-029 Macro FC_LAYER_SCHED_RELU_EN defined: value captured in WAIT = (dp_sum<0) ? 0 : dp_sum.
REQ-030 Macro FC_LAYER_SCHED_RELU_EN undefined: dp_sum captured unchanged, negative values preserved.

Verification
REQ-031 Reset then start pulse, out_ready=1, dp_sum = 100+w_addr -> out_data 100..109, out_idx 0..9, done exactly at cycle T+31.
REQ-032 out_ready low 5 cycles in OUTPUT of index 3 -> out_valid, out_data=103, out_idx=3 held stable; no w_rd_en until acceptance.
REQ-033 start held high for whole pass -> exactly one pass, w_rd_en count =10, single done pulse, then new pass starts from IDLE.
REQ-034 rst_n low during WAIT of index 6 -> all outputs 0 asynchronously, no done; next start yields w_addr=0 first.
REQ-035 dp_sum=-5 for index 2 -> out_data=0 with FC_LAYER_SCHED_RELU_EN, out_data=-5 without.
